// File: rtl/lsu_ctrl_if.sv
// Core data port and slave bus of the load/store unit, grouped as one bundle.
// The LSU uses the slave modport; the core/slave side uses the master modport.
interface lsu_ctrl_if #(
  parameter int NUM_SLAVES = 3
);
  logic                    core_req_i;
  logic                    core_we_i;
  logic [1:0]              core_hb_i;
  logic                    core_unsigned_i;
  logic [31:0]             core_addr_i;
  logic [31:0]             core_wdata_i;
  logic [31:0]             core_rdata_o;
  logic                    core_ready_o;
  logic                    core_err_o;
  logic [31:0]             bus_addr_o;
  logic [31:0]             bus_wdata_o;
  logic                    bus_we_o;
  logic [1:0]              bus_hb_o;
  logic [NUM_SLAVES-1:0]   bus_cs_o;
  logic [NUM_SLAVES*32-1:0] bus_rdata_i;
  logic [NUM_SLAVES-1:0]   bus_ack_i;

  modport slave (
    input  core_req_i, core_we_i, core_hb_i, core_unsigned_i, core_addr_i, core_wdata_i,
    output core_rdata_o, core_ready_o, core_err_o,
    output bus_addr_o, bus_wdata_o, bus_we_o, bus_hb_o, bus_cs_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport master (
    output core_req_i, core_we_i, core_hb_i, core_unsigned_i, core_addr_i, core_wdata_i,
    input  core_rdata_o, core_ready_o, core_err_o,
    input  bus_addr_o, bus_wdata_o, bus_we_o, bus_hb_o, bus_cs_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Registered load/store unit: address decode + rebase, req/ack handshake with
// timeout, store lane steering, load extraction with sign/zero extension.
module lsu_ctrl #(
  parameter int NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE = (NUM_SLAVES*32)'({32'h0000_0100, 32'h0000_0000}),
  parameter logic [NUM_SLAVES*32-1:0] SLV_SIZE = (NUM_SLAVES*32)'({32'd256, 32'd256}),
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  lsu_ctrl_if.slave  io
);
  localparam int          SW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;

  logic [SW-1:0]         sel_q, dec_idx;
  logic [1:0]            off_q;
  logic                  uns_q, err_q;
  logic [31:0]           rdata_q, cnt_q;
  logic [NUM_SLAVES-1:0] bus_cs_q;
  logic [31:0]           bus_addr_q, bus_wdata_q;
  logic                  bus_we_q;
  logic [1:0]            bus_hb_q;

  logic [31:0] dec_base, steer_wd, sel_rdata, sh_rdata, ld_data;
  logic        misalign, ack_sel, timeout;

  assign misalign = (io.core_hb_i == 2'b11) ||
                    (io.core_hb_i == 2'b01 && io.core_addr_i[0]) ||
                    (io.core_hb_i == 2'b10 && io.core_addr_i[1:0] != 2'b00);
  assign ack_sel  = io.bus_ack_i[sel_q];
  assign timeout  = TO_EN && (cnt_q == TO_LAST);

  // Window decode; iterating downward lets the lowest matching index win.
  // 33-bit compares keep a window touching 0xFFFF_FFFF from wrapping.
  always_comb begin
    dec_idx  = SW'(NUM_SLAVES - 1);
    dec_base = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (SLV_SIZE[32*i +: 32] != 32'd0 &&
          {1'b0, io.core_addr_i} >= {1'b0, SLV_BASE[32*i +: 32]} &&
          {1'b0, io.core_addr_i} <= {1'b0, SLV_BASE[32*i +: 32]} + {1'b0, SLV_SIZE[32*i +: 32]} - 33'd1) begin
        dec_idx  = SW'(i);
        dec_base = SLV_BASE[32*i +: 32];
      end
    end
  end

  // Store data placed on the lane(s) selected by the low address bits.
  always_comb begin
    case (io.core_hb_i)
      2'b00:   steer_wd = {24'd0, io.core_wdata_i[7:0]} << {io.core_addr_i[1:0], 3'b000};
      2'b01:   steer_wd = {16'd0, io.core_wdata_i[15:0]} << {io.core_addr_i[1], 4'b0000};
      default: steer_wd = io.core_wdata_i;
    endcase
  end

  // Load lane extraction and extension from the selected slave's read data.
  assign sel_rdata = io.bus_rdata_i[32*sel_q +: 32];
  assign sh_rdata  = sel_rdata >> {off_q, 3'b000};
  always_comb begin
    case (bus_hb_q)
      2'b00:   ld_data = uns_q ? {24'd0, sh_rdata[7:0]}  : {{24{sh_rdata[7]}},  sh_rdata[7:0]};
      2'b01:   ld_data = uns_q ? {16'd0, sh_rdata[15:0]} : {{16{sh_rdata[15]}}, sh_rdata[15:0]};
      default: ld_data = sel_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: illegal requests skip the bus; ack beats timeout on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.core_req_i) state_d = misalign ? RESP : ACCESS;
      ACCESS:  if (ack_sel || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, bus drive registers, wait counter and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q <= '0; off_q <= '0; uns_q <= 1'b0; err_q <= 1'b0;
      rdata_q <= '0; cnt_q <= '0;
      bus_cs_q <= '0; bus_addr_q <= '0; bus_wdata_q <= '0; bus_we_q <= 1'b0; bus_hb_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (io.core_req_i) begin
          off_q   <= io.core_addr_i[1:0];
          uns_q   <= io.core_unsigned_i;
          err_q   <= misalign;
          rdata_q <= '0;
          cnt_q   <= '0;
          if (!misalign) begin
            sel_q       <= dec_idx;
            bus_cs_q    <= NUM_SLAVES'(1) << dec_idx;
            bus_addr_q  <= io.core_addr_i - dec_base;
            bus_wdata_q <= steer_wd;
            bus_we_q    <= io.core_we_i;
            bus_hb_q    <= io.core_hb_i;
          end
        end
        ACCESS: begin
          if (ack_sel || timeout) begin
            err_q       <= !ack_sel;
            rdata_q     <= (ack_sel && !bus_we_q) ? ld_data : '0;
            bus_cs_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_hb_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.core_ready_o = (state_q == RESP);
  assign io.core_err_o   = io.core_ready_o & err_q;
  assign io.core_rdata_o = io.core_ready_o ? rdata_q : '0;
  assign io.bus_cs_o     = bus_cs_q;
  assign io.bus_addr_o   = bus_addr_q;
  assign io.bus_wdata_o  = bus_wdata_q;
  assign io.bus_we_o     = bus_we_q;
  assign io.bus_hb_o     = bus_hb_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed plan cases, randomized accesses against a
// behavioural model, back-to-back throughput and reset in mid-access.
module tb_lsu_ctrl;
  localparam int NS = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.NUM_SLAVES(NS)) bus_if();
  lsu_ctrl #(.NUM_SLAVES(NS), .TIMEOUT_CYC(TO)) dut (.clk_i(clk), .rst_i(rst), .io(bus_if.slave));

  logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0000};
  logic [31:0] m_size [NS] = '{32'd256, 32'd256, 32'd0};

  int n_chk = 0;
  int n_fail = 0;

  // Monitor results of the last run_txn
  int          m_lat;
  logic        m_err, m_we, m_stable, m_cs_any, m_pulse1;
  logic [31:0] m_rdata, m_baddr, m_bwd;
  logic [1:0]  m_bhb;
  logic [2:0]  m_cs, m_cs_rdy;

  // ---------------- reference model ----------------
  function automatic int ref_sel(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (m_size[i] != 0 && longint'(a) >= longint'(m_base[i]) &&
          longint'(a) < longint'(m_base[i]) + longint'(m_size[i])) return i;
    return NS - 1;
  endfunction

  function automatic logic ref_legal(input logic [1:0] hb, input logic [31:0] a);
    return !(hb == 3 || (hb == 1 && a % 2 != 0) || (hb == 2 && a % 4 != 0));
  endfunction

  function automatic logic [31:0] ref_store(input logic [1:0] hb, input logic [31:0] a, input logic [31:0] wd);
    if (hb == 0) return (wd & 32'hFF) << (8 * (a % 4));
    if (hb == 1) return (wd & 32'hFFFF) << (16 * ((a / 2) % 2));
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] hb, input logic [31:0] a, input logic uns, input logic [31:0] rd);
    logic [31:0] v;
    if (hb == 0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 128) v = v - 32'd256;
    end else if (hb == 1) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 32'd65536;
    end else v = rd;
    return v;
  endfunction

  // ---------------- driver / monitor ----------------
  // Issues one request and plays the slave side: the selected slave acks on
  // ACCESS cycle ack_wait (0-based, -1 = never), unselected slaves ack randomly.
  task automatic run_txn(input logic we, input logic [1:0] hb, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_wait, input int slot);
    @(negedge clk);
    for (int s = 0; s < NS; s++) bus_if.bus_rdata_i[32*s +: 32] = (s == slot) ? rd : $urandom;
    bus_if.bus_ack_i       = '0;
    bus_if.core_req_i      = 1'b1;
    bus_if.core_we_i       = we;
    bus_if.core_hb_i       = hb;
    bus_if.core_unsigned_i = uns;
    bus_if.core_addr_i     = addr;
    bus_if.core_wdata_i    = wd;
    m_lat = -1; m_err = 1'b0; m_rdata = '0; m_cs = '0; m_baddr = '0; m_bwd = '0;
    m_we = 1'b0; m_bhb = '0; m_stable = 1'b1; m_cs_any = 1'b0; m_cs_rdy = '0;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_if.core_req_i      = 1'b0;
        bus_if.core_we_i       = 1'($urandom);
        bus_if.core_hb_i       = 2'($urandom);
        bus_if.core_unsigned_i = 1'($urandom);
        bus_if.core_addr_i     = $urandom;
        bus_if.core_wdata_i    = $urandom;
      end
      m_cs_any = m_cs_any | (|bus_if.bus_cs_o);
      if (bus_if.core_ready_o) begin
        m_lat = k; m_err = bus_if.core_err_o; m_rdata = bus_if.core_rdata_o; m_cs_rdy = bus_if.bus_cs_o;
        break;
      end
      if (k == 1) begin
        m_cs = bus_if.bus_cs_o; m_baddr = bus_if.bus_addr_o; m_bwd = bus_if.bus_wdata_o;
        m_we = bus_if.bus_we_o; m_bhb = bus_if.bus_hb_o;
      end else if (m_cs !== bus_if.bus_cs_o || m_baddr !== bus_if.bus_addr_o || m_bwd !== bus_if.bus_wdata_o ||
                   m_we !== bus_if.bus_we_o || m_bhb !== bus_if.bus_hb_o) m_stable = 1'b0;
      bus_if.bus_ack_i = (3'($urandom) & ~bus_if.bus_cs_o) | ((k - 1 == ack_wait) ? bus_if.bus_cs_o : 3'b000);
    end
    bus_if.bus_ack_i = '0;
    @(negedge clk);
    m_pulse1 = !bus_if.core_ready_o;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus_if.core_req_i = 1'b1; bus_if.core_we_i = 1'b0; bus_if.core_hb_i = 2'b10;
    bus_if.core_unsigned_i = 1'b0; bus_if.core_addr_i = 32'h104; bus_if.core_wdata_i = '0;
    bus_if.bus_rdata_i = '0; bus_if.bus_ack_i = '0;
    repeat (3) @(negedge clk);
    n_chk++; if ({bus_if.core_ready_o, bus_if.core_err_o, bus_if.core_rdata_o, bus_if.bus_cs_o, bus_if.bus_addr_o,
                  bus_if.bus_wdata_o, bus_if.bus_we_o, bus_if.bus_hb_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got ready=%b cs=%b addr=%h not all zero", bus_if.core_ready_o, bus_if.bus_cs_o, bus_if.bus_addr_o);
    end
    bus_if.core_req_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus_if.core_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_ready got %b exp 0", bus_if.core_ready_o); end
  endtask

  task automatic test_plan();
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 1);
    n_chk++; if (m_cs !== 3'b010) begin n_fail++; $display("FAIL word_load_cs got %b exp 010", m_cs); end
    n_chk++; if (m_baddr !== 32'h4) begin n_fail++; $display("FAIL word_load_addr got %h exp 4", m_baddr); end
    n_chk++; if (m_lat !== 2 || m_err !== 1'b0) begin n_fail++; $display("FAIL word_load_lat got %0d err %b exp 2 err 0", m_lat, m_err); end
    n_chk++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_load_data got %h exp deadbeef", m_rdata); end

    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 32'h8012_3456, 0, 0);
    n_chk++; if (m_rdata !== 32'hFFFF_FF80 || m_cs !== 3'b001) begin n_fail++; $display("FAIL byte_signed got %h cs %b exp ffffff80 cs 001", m_rdata, m_cs); end
    run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 32'h8012_3456, 0, 0);
    n_chk++; if (m_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_unsigned got %h exp 00000080", m_rdata); end

    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 32'h1234_5678, 0, 1);
    n_chk++; if (m_bwd !== 32'hABCD_0000 || m_we !== 1'b1) begin n_fail++; $display("FAIL half_store_wdata got %h we %b exp abcd0000 we 1", m_bwd, m_we); end
    n_chk++; if (m_baddr !== 32'h2 || m_bhb !== 2'b01) begin n_fail++; $display("FAIL half_store_addr got %h hb %b exp 2 hb 01", m_baddr, m_bhb); end
    n_chk++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL half_store_rdata got %h exp 0", m_rdata); end

    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0106, 32'h5555_5555, 32'h0, 0, 1);
    n_chk++; if (m_lat !== 1 || m_err !== 1'b1 || m_cs_any !== 1'b0) begin n_fail++; $display("FAIL misaligned_word got lat %0d err %b cs_seen %b exp 1 1 0", m_lat, m_err, m_cs_any); end
    run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0, 1);
    n_chk++; if (m_lat !== 1 || m_err !== 1'b1 || m_cs_any !== 1'b0) begin n_fail++; $display("FAIL illegal_size got lat %0d err %b cs_seen %b exp 1 1 0", m_lat, m_err, m_cs_any); end

    run_txn(1'b0, 2'b10, 1'b0, 32'h1000_0000, 32'h0, 32'hCAFE_F00D, -1, 2);
    n_chk++; if (m_cs !== 3'b100 || m_baddr !== 32'h1000_0000) begin n_fail++; $display("FAIL unmapped_decode got cs %b addr %h exp 100 10000000", m_cs, m_baddr); end
    n_chk++; if (m_lat !== TO + 1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout got lat %0d err %b data %h exp %0d 1 0", m_lat, m_err, m_rdata, TO + 1); end
    n_chk++; if (m_cs_rdy !== 3'b000) begin n_fail++; $display("FAIL timeout_cs_drop got %b exp 000", m_cs_rdy); end
    run_txn(1'b0, 2'b10, 1'b0, 32'h1000_0000, 32'h0, 32'hCAFE_F00D, 5, 2);
    n_chk++; if (m_lat !== 7 || m_err !== 1'b0 || m_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wait5 got lat %0d err %b data %h exp 7 0 cafef00d", m_lat, m_err, m_rdata); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      logic        we, uns, legal, tmo, e_err;
      logic [1:0]  hb;
      logic [31:0] addr, wd, rd, e_rdata;
      int          aw, sel, n, pick;
      we = 1'($urandom); uns = 1'($urandom); hb = 2'($urandom);
      wd = $urandom; rd = $urandom;
      pick = $urandom_range(0, 3);
      addr = (pick == 0) ? $urandom : (pick == 1) ? (32'h1000_0000 + $urandom_range(0, 15)) : $urandom_range(0, 32'h1FF);
      aw = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 18);
      sel   = ref_sel(addr);
      legal = ref_legal(hb, addr);
      tmo   = !(aw >= 0 && aw < TO);
      n     = tmo ? TO : aw + 1;
      e_err = !legal || tmo;
      e_rdata = (e_err || we) ? 32'h0 : ref_load(hb, addr, uns, rd);
      run_txn(we, hb, uns, addr, wd, rd, aw, sel);
      n_chk++; if (m_lat !== (legal ? n + 1 : 1)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d exp %0d", t, m_lat, legal ? n + 1 : 1); end
      n_chk++; if (m_err !== e_err) begin n_fail++; $display("FAIL rnd%0d_err got %b exp %b", t, m_err, e_err); end
      n_chk++; if (m_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata got %h exp %h", t, m_rdata, e_rdata); end
      n_chk++; if (m_pulse1 !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ready_width got extra ready cycle exp single pulse", t); end
      if (legal) begin
        n_chk++; if (m_cs !== 3'(1 << sel) || m_baddr !== addr - m_base[sel]) begin n_fail++; $display("FAIL rnd%0d_decode got cs %b addr %h exp %b %h", t, m_cs, m_baddr, 3'(1 << sel), addr - m_base[sel]); end
        n_chk++; if (m_bwd !== ref_store(hb, addr, wd) || m_we !== we || m_bhb !== hb) begin n_fail++; $display("FAIL rnd%0d_bus got wd %h we %b hb %b exp %h %b %b", t, m_bwd, m_we, m_bhb, ref_store(hb, addr, wd), we, hb); end
        n_chk++; if (m_stable !== 1'b1 || m_cs_rdy !== 3'b000) begin n_fail++; $display("FAIL rnd%0d_bus_hold got stable %b cs_at_ready %b exp 1 000", t, m_stable, m_cs_rdy); end
      end else begin
        n_chk++; if (m_cs_any !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_illegal_cs got cs asserted exp none", t); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    @(negedge clk);
    bus_if.bus_rdata_i = {32'h0, 32'h1357_2468, 32'h0};
    bus_if.bus_ack_i   = 3'b010;
    bus_if.core_req_i = 1'b1; bus_if.core_we_i = 1'b0; bus_if.core_hb_i = 2'b10;
    bus_if.core_unsigned_i = 1'b0; bus_if.core_addr_i = 32'h104;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_rdy = (k % 3 == 2);
      n_chk++; if (bus_if.core_ready_o !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready_k%0d got %b exp %b", k, bus_if.core_ready_o, exp_rdy); end
      if (exp_rdy) begin
        n_chk++; if (bus_if.core_rdata_o !== 32'h1357_2468) begin n_fail++; $display("FAIL b2b_data_k%0d got %h exp 13572468", k, bus_if.core_rdata_o); end
      end
    end
    bus_if.core_req_i = 1'b0;
    bus_if.bus_ack_i  = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    bus_if.bus_rdata_i = {32'h7777_8888, 64'h0};
    bus_if.core_req_i = 1'b1; bus_if.core_we_i = 1'b0; bus_if.core_hb_i = 2'b10;
    bus_if.core_addr_i = 32'h1000_0000;
    @(negedge clk);
    bus_if.core_req_i = 1'b0;
    n_chk++; if (bus_if.bus_cs_o !== 3'b100) begin n_fail++; $display("FAIL rstmid_access got cs %b exp 100", bus_if.bus_cs_o); end
    @(negedge clk);
    rst = 1'b1;
    bus_if.bus_ack_i = 3'b100;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if ({bus_if.core_ready_o, bus_if.core_err_o, bus_if.core_rdata_o, bus_if.bus_cs_o, bus_if.bus_addr_o,
                  bus_if.bus_wdata_o, bus_if.bus_we_o, bus_if.bus_hb_o} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs got ready=%b cs=%b addr=%h not all zero", bus_if.core_ready_o, bus_if.bus_cs_o, bus_if.bus_addr_o);
    end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | bus_if.core_ready_o | (|bus_if.bus_cs_o); end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped got late ready/cs exp none"); end
    bus_if.bus_ack_i = '0;
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 0, 1);
    n_chk++; if (m_lat !== 2 || m_err !== 1'b0 || m_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rstmid_recover got lat %0d err %b data %h exp 2 0 0badf00d", m_lat, m_err, m_rdata); end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
